// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory read port plus the ir handshake toward decode.
// master = fetch_unit, slave = memory/decode side.
interface fetch_unit_if #(
   parameter int ADDR_W = 5,
   parameter int INST_W = 13
);
   logic [ADDR_W-1:0] mem_addr;
   logic [INST_W-1:0] mem_inst;
   logic [INST_W-1:0] ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;

   modport master (
      output mem_addr, ir, ir_pc, ir_valid,
      input  mem_inst, ir_ready
   );

   modport slave (
      input  mem_addr, ir, ir_pc, ir_valid,
      output mem_inst, ir_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, async-read memory address, ir register with valid/ready to decode.
// ir lands one edge after the PC presents its address; ir_ready low stalls pc and ir in place.
module fetch_unit #(
   parameter int                ADDR_W     = 5,
   parameter int                INST_W     = 13,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter bit                HALT_EN    = 1'b1,
   parameter logic [INST_W-1:0] HALT_WORD  = '0,
   parameter int                CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   fetch_unit_if.master      bus,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  inst_count
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [INST_W-1:0] ir_q;
   logic [ADDR_W-1:0] ir_pc_q;
   logic              ir_valid_q;

   logic xfer;
   logic load;
   logic is_halt;
   logic cnt_max;

   assign bus.mem_addr = pc;
   assign bus.ir       = ir_q;
   assign bus.ir_pc    = ir_pc_q;
   assign bus.ir_valid = ir_valid_q;

   assign xfer    = ir_valid_q && bus.ir_ready;
   assign load    = !redirect && (!ir_valid_q || bus.ir_ready);
   assign is_halt = (HALT_EN != 1'b0) && (bus.mem_inst == HALT_WORD);
   assign cnt_max = &inst_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= START_ADDR;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         inst_count <= '0;
         busy       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         if (xfer && !cnt_max)
            inst_count <= inst_count + CNT_W'(1);

         case (state)
            RUN: begin
               // redirect outranks both load and halt; the held word is flushed
               if (redirect) begin
                  pc         <= redirect_addr;
                  ir_valid_q <= 1'b0;
               end else if (load) begin
                  if (is_halt) begin
                     ir_valid_q <= 1'b0;
                     state      <= HALT;
                     busy       <= 1'b0;
                     halted     <= 1'b1;
                  end else begin
                     ir_q       <= bus.mem_inst;
                     ir_pc_q    <= pc;
                     ir_valid_q <= 1'b1;
                     pc         <= pc + ADDR_W'(1);
                  end
               end
            end
            IDLE, HALT: begin
               if (xfer)
                  ir_valid_q <= 1'b0;
               if (start) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  halted     <= 1'b0;
                  pc         <= START_ADDR;
                  inst_count <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule
